// File: rtl/pc_sequencer_if.sv
// Handshake and PC-control bundle between the instruction-cycle sequencer and
// its environment (instruction memory, core, program counter).
interface pc_sequencer_if #(
    parameter int WORD_SIZE   = 16,
    parameter int COUNT_WIDTH = 16
);
    logic                   start;
    logic                   fetch_ready;
    logic                   instr_done;
    logic                   branch_taken;
    logic [WORD_SIZE-1:0]   branch_offset;
    logic                   halt;

    logic                   fetch_req;
    logic                   pc_reset_enable;
    logic                   pc_update_enable;
    logic [WORD_SIZE-1:0]   pc_value;
    logic [2:0]             state;
    logic                   busy;
    logic [COUNT_WIDTH-1:0] retired_count;

    // The sequencer drives the PC controls and fetch requests.
    modport master (
        input  start, fetch_ready, instr_done, branch_taken, branch_offset, halt,
        output fetch_req, pc_reset_enable, pc_update_enable, pc_value, state, busy,
               retired_count
    );

    modport slave (
        output start, fetch_ready, instr_done, branch_taken, branch_offset, halt,
        input  fetch_req, pc_reset_enable, pc_update_enable, pc_value, state, busy,
               retired_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller: CLEAR -> FETCH -> EXECUTE -> UPDATE, driving the
// program counter's reset/update strobes and delta value, and counting retirements.
module pc_sequencer #(
    parameter int WORD_SIZE   = 16,
    parameter int COUNT_WIDTH = 16
) (
    input logic             clock,
    input logic             reset_n,
    pc_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FETCH   = 3'd2,
        S_EXECUTE = 3'd3,
        S_UPDATE  = 3'd4,
        S_HALTED  = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [WORD_SIZE-1:0]   pc_value_q, pc_value_d;
    logic [COUNT_WIDTH-1:0] retired_count_q, retired_count_d;
    logic [COUNT_WIDTH-1:0] count_inc;

    assign count_inc = (retired_count_q == '1) ? retired_count_q
                                               : retired_count_q + COUNT_WIDTH'(1);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        state_d         = state_q;
        pc_value_d      = pc_value_q;
        retired_count_d = retired_count_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                retired_count_d = '0;
                state_d         = S_FETCH;
            end
            S_FETCH: begin
                if (bus.fetch_ready) state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (bus.instr_done) begin
                    // Halt takes priority over a branch and suppresses the PC update.
                    if (bus.halt) begin
                        retired_count_d = count_inc;
                        state_d         = S_HALTED;
                    end else begin
                        pc_value_d = bus.branch_taken ? bus.branch_offset : WORD_SIZE'(1);
                        state_d    = S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                retired_count_d = count_inc;
                state_d         = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            pc_value_q      <= '0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_value_q      <= pc_value_d;
            retired_count_q <= retired_count_d;
        end
    end

    // Moore outputs: a reset forces state_q to IDLE, so strobes drop immediately.
    assign bus.fetch_req        = (state_q == S_FETCH);
    assign bus.pc_reset_enable  = (state_q == S_CLEAR);
    assign bus.pc_update_enable = (state_q == S_UPDATE);
    assign bus.busy             = (state_q == S_CLEAR) || (state_q == S_FETCH) ||
                                  (state_q == S_EXECUTE) || (state_q == S_UPDATE);
    assign bus.state            = state_q;
    assign bus.pc_value         = pc_value_q;
    assign bus.retired_count    = retired_count_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural PC follows the strobes, and a
// second instance with a 2-bit counter exercises saturation.
module tb_pc_sequencer;
    logic clock = 1'b0;
    logic reset_n;
    int   tests  = 0;
    int   failed = 0;

    always #5 clock = ~clock;

    pc_sequencer_if #(.WORD_SIZE(16), .COUNT_WIDTH(16)) bus ();
    pc_sequencer_if #(.WORD_SIZE(16), .COUNT_WIDTH(2))  bus2 ();

    pc_sequencer #(.WORD_SIZE(16), .COUNT_WIDTH(16)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    pc_sequencer #(.WORD_SIZE(16), .COUNT_WIDTH(2)) u_sat (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2.master)
    );

    // Program counter fed by the sequencer's strobes.
    logic [15:0] pc_model   = 16'h0;
    int          upd_pulses = 0;
    always @(posedge clock) begin
        if (bus.pc_reset_enable) pc_model <= 16'h0;
        else if (bus.pc_update_enable) begin
            pc_model   <= pc_model + bus.pc_value;
            upd_pulses <= upd_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        check("strobe_exclusive", {31'd0, bus.pc_reset_enable & bus.pc_update_enable}, 32'd0);
    endtask

    // One instruction from FETCH: memory answers at once, core takes one extra cycle.
    task automatic run_instr(input logic br, input logic [15:0] off, input logic hlt);
        bus.fetch_ready = 1'b1;
        cyc();
        check("exec_entry", bus.state, 3);
        bus.fetch_ready = 1'b0;
        cyc();
        check("exec_wait", bus.state, 3);
        bus.instr_done    = 1'b1;
        bus.branch_taken  = br;
        bus.branch_offset = off;
        bus.halt          = hlt;
        cyc();
        bus.instr_done    = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 16'h0;
        bus.halt          = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        {bus.start, bus.fetch_ready, bus.instr_done, bus.branch_taken, bus.halt} = '0;
        bus.branch_offset = 16'h0;
        {bus2.start, bus2.fetch_ready, bus2.instr_done, bus2.branch_taken, bus2.halt} = '0;
        bus2.branch_offset = 16'h0;
        #12;
        check("rst_state", bus.state, 0);
        check("rst_outputs", {bus.fetch_req, bus.pc_reset_enable, bus.pc_update_enable, bus.busy}, 0);
        check("rst_pc_value", bus.pc_value, 0);
        check("rst_count", bus.retired_count, 0);
        cyc();
        reset_n = 1'b1;
        cyc();
        check("idle_hold", bus.state, 0);

        // Start: one CLEAR cycle then FETCH.
        bus.start = 1'b1;
        cyc();
        check("clear_state", bus.state, 1);
        check("clear_pc_reset", bus.pc_reset_enable, 1);
        check("clear_busy", bus.busy, 1);
        bus.start = 1'b0;
        cyc();
        check("fetch_state", bus.state, 2);
        check("fetch_req", bus.fetch_req, 1);

        // Four sequential instructions: PC 0,1,2,3,4.
        for (int i = 0; i < 4; i++) begin
            check("seq_pc", pc_model, i);
            run_instr(1'b0, 16'h0, 1'b0);
            check("seq_update_state", bus.state, 4);
            check("seq_update_pulse", bus.pc_update_enable, 1);
            check("seq_pc_value", bus.pc_value, 1);
            cyc();
            check("seq_back_fetch", bus.state, 2);
            check("seq_count", bus.retired_count, i + 1);
        end
        check("seq_pc_final", pc_model, 4);
        check("seq_pulses", upd_pulses, 4);

        // Fifth instruction brings PC to 5, then a backward branch of -2.
        run_instr(1'b0, 16'h0, 1'b0);
        cyc();
        check("pc_five", pc_model, 5);
        run_instr(1'b1, 16'hFFFE, 1'b0);
        check("br_update_pulse", bus.pc_update_enable, 1);
        check("br_pc_value", bus.pc_value, 16'hFFFE);
        cyc();
        check("br_pc", pc_model, 3);
        check("br_value_held", bus.pc_value, 16'hFFFE);
        check("br_count", bus.retired_count, 6);

        // Halt together with a branch: halt wins, no PC update.
        run_instr(1'b1, 16'h0007, 1'b1);
        check("halt_state", bus.state, 5);
        check("halt_busy", bus.busy, 0);
        check("halt_no_update", bus.pc_update_enable, 0);
        check("halt_count", bus.retired_count, 7);
        check("halt_value_held", bus.pc_value, 16'hFFFE);
        bus.fetch_ready = 1'b1;
        cyc();
        bus.fetch_ready = 1'b0;
        check("halt_ignores_ready", bus.state, 5);
        check("halt_pulses", upd_pulses, 6);
        check("halt_pc", pc_model, 3);

        // Restart from HALTED.
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("restart_clear", bus.pc_reset_enable, 1);
        check("restart_count_hold", bus.retired_count, 7);
        cyc();
        check("restart_fetch", bus.state, 2);
        check("restart_pc", pc_model, 0);
        check("restart_count", bus.retired_count, 0);

        // Memory stalls 10 cycles while the core raises a spurious instr_done.
        bus.instr_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall_fetch_req", bus.fetch_req, 1);
            check("stall_state", bus.state, 2);
            cyc();
        end
        bus.instr_done = 1'b0;
        check("stall_count", bus.retired_count, 0);
        run_instr(1'b0, 16'h0, 1'b0);
        cyc();
        check("post_stall_pc", pc_model, 1);
        check("post_stall_count", bus.retired_count, 1);

        // Asynchronous reset mid-FETCH.
        check("pre_reset_fetch", bus.state, 2);
        reset_n = 1'b0;
        #1;
        check("async_rst_state", bus.state, 0);
        check("async_rst_fetch_req", bus.fetch_req, 0);
        check("async_rst_update", bus.pc_update_enable, 0);
        check("async_rst_count", bus.retired_count, 0);
        check("async_rst_pc_value", bus.pc_value, 0);
        cyc();
        reset_n = 1'b1;
        cyc();
        check("async_rst_stays_idle", bus.state, 0);

        // Saturating 2-bit retirement counter.
        bus2.start = 1'b1;
        cyc();
        bus2.start = 1'b0;
        cyc();
        check("sat_fetch", bus2.state, 2);
        for (int i = 0; i < 4; i++) begin
            bus2.fetch_ready = 1'b1;
            cyc();
            bus2.fetch_ready = 1'b0;
            bus2.instr_done  = 1'b1;
            cyc();
            bus2.instr_done  = 1'b0;
            cyc();
            check("sat_count", bus2.retired_count, (i + 1 > 3) ? 3 : i + 1);
        end
        bus2.fetch_ready = 1'b1;
        cyc();
        bus2.fetch_ready = 1'b0;
        bus2.instr_done  = 1'b1;
        bus2.halt        = 1'b1;
        cyc();
        bus2.instr_done  = 1'b0;
        bus2.halt        = 1'b0;
        check("sat_halt_state", bus2.state, 5);
        check("sat_halt_count", bus2.retired_count, 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
